// File: rtl/ysyx_25020081_imm_pkg.sv
// Shared definitions for the immediate-extension pipeline: format select
// codes and the occupancy state of the two-entry output queue.
// Optional feature macro: YSYX_25020081_IMM_ZICSR_EN (enables the CSR zimm format).
package ysyx_25020081_imm_pkg;

    // Immediate format select codes
    localparam logic [2:0] EXT_I     = 3'b000;
    localparam logic [2:0] EXT_U     = 3'b001;
    localparam logic [2:0] EXT_S     = 3'b010;
    localparam logic [2:0] EXT_B     = 3'b011;
    localparam logic [2:0] EXT_J     = 3'b100;
    localparam logic [2:0] EXT_SHAMT = 3'b101;
    localparam logic [2:0] EXT_Z     = 3'b110;
    localparam logic [2:0] EXT_RSVD  = 3'b111;

    // Number of results currently held in the output queue
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_e;

endpackage

// File: rtl/ysyx_25020081_imm_dec.sv
// Combinational immediate decoder. Takes instruction bits [31:7] (so
// inst_s[k] is instruction bit k+7) and a format select, and produces the
// XLEN-wide extended immediate plus an error flag for unsupported formats.
// Every format is first assembled as a 32-bit value, then widened to XLEN
// either sign- or zero-extending, so XLEN=32 and XLEN=64 share one path.
// Optional feature macro: YSYX_25020081_IMM_ZICSR_EN (enables the CSR zimm format).
module ysyx_25020081_imm_dec
    import ysyx_25020081_imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [24:0]     inst_s,
    input  logic [2:0]      ext_op_s,
    output logic [XLEN-1:0] imm_s,
    output logic            err_s
);

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        return XLEN'(v);
    endfunction

    // Select and extend the immediate field for the requested format
    always_comb begin
        imm_s = {XLEN{1'b0}};
        err_s = 1'b0;
        case (ext_op_s)
            EXT_I: imm_s = sext32({{20{inst_s[24]}}, inst_s[24:13]});
            EXT_U: imm_s = sext32({inst_s[24:5], 12'h000});
            EXT_S: imm_s = sext32({{20{inst_s[24]}}, inst_s[24:18], inst_s[4:0]});
            EXT_B: imm_s = sext32({{19{inst_s[24]}}, inst_s[24], inst_s[0],
                                   inst_s[23:18], inst_s[4:1], 1'b0});
            EXT_J: imm_s = sext32({{11{inst_s[24]}}, inst_s[24], inst_s[12:5],
                                   inst_s[13], inst_s[23:14], 1'b0});
            EXT_SHAMT: begin
                if (XLEN == 64) begin
                    imm_s = zext32({26'd0, inst_s[18:13]});
                end else begin
                    imm_s = zext32({27'd0, inst_s[17:13]});
                end
            end
            EXT_Z: begin
`ifdef YSYX_25020081_IMM_ZICSR_EN
                imm_s = zext32({27'd0, inst_s[12:8]});
`else
                err_s = 1'b1;
`endif
            end
            EXT_RSVD: err_s = 1'b1;
            default:  err_s = 1'b1;
        endcase
    end

endmodule

// File: rtl/ysyx_25020081_imm_pipe.sv
// Immediate-extension pipeline stage. Decodes the immediate, forms
// pc + imm, and buffers results in a two-entry in-order queue. Outputs come
// straight from the head entry registers; in_ready depends only on queue
// occupancy (and is held low while reset is asserted).
// Optional feature macro: YSYX_25020081_IMM_ZICSR_EN (enables the CSR zimm format).
module ysyx_25020081_imm_pipe
    import ysyx_25020081_imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      in_inst,
    input  logic [2:0]       in_ext_op,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [XLEN-1:0]  out_target,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    logic [XLEN-1:0]  dec_imm_s;
    logic             dec_err_s;
    logic [XLEN-1:0]  dec_target_s;

    occ_state_e       state_r;
    occ_state_e       state_next_s;

    logic [XLEN-1:0]  head_imm_r;
    logic [XLEN-1:0]  head_target_r;
    logic [TAG_W-1:0] head_tag_r;
    logic             head_err_r;

    logic [XLEN-1:0]  tail_imm_r;
    logic [XLEN-1:0]  tail_target_r;
    logic [TAG_W-1:0] tail_tag_r;
    logic             tail_err_r;

    logic             push_s;
    logic             pop_s;
    logic             head_from_in_s;
    logic             head_from_tail_s;
    logic             tail_from_in_s;

    ysyx_25020081_imm_dec #(
        .XLEN(XLEN)
    ) u_dec (
        .inst_s  (in_inst),
        .ext_op_s(in_ext_op),
        .imm_s   (dec_imm_s),
        .err_s   (dec_err_s)
    );

    // Unsupported formats decode to imm 0, so the target degenerates to pc
    assign dec_target_s = in_pc + dec_imm_s;

    assign in_ready   = rst_n && (state_r != OCC_TWO);
    assign out_valid  = (state_r != OCC_EMPTY);
    assign out_imm    = head_imm_r;
    assign out_target = head_target_r;
    assign out_tag    = head_tag_r;
    assign out_err    = head_err_r;

    assign push_s = in_valid && in_ready;
    assign pop_s  = out_valid && out_ready;

    // Queue control: next occupancy and which entry registers load
    always_comb begin
        state_next_s     = state_r;
        head_from_in_s   = 1'b0;
        head_from_tail_s = 1'b0;
        tail_from_in_s   = 1'b0;
        case (state_r)
            OCC_EMPTY: begin
                if (push_s) begin
                    head_from_in_s = 1'b1;
                    state_next_s   = OCC_ONE;
                end else begin
                    state_next_s   = OCC_EMPTY;
                end
            end
            OCC_ONE: begin
                if (push_s && pop_s) begin
                    head_from_in_s = 1'b1;
                    state_next_s   = OCC_ONE;
                end else if (push_s) begin
                    tail_from_in_s = 1'b1;
                    state_next_s   = OCC_TWO;
                end else if (pop_s) begin
                    state_next_s   = OCC_EMPTY;
                end else begin
                    state_next_s   = OCC_ONE;
                end
            end
            OCC_TWO: begin
                // No push can occur here because in_ready is low
                if (pop_s) begin
                    head_from_tail_s = 1'b1;
                    state_next_s     = OCC_ONE;
                end else begin
                    state_next_s     = OCC_TWO;
                end
            end
            default: begin
                state_next_s = OCC_EMPTY;
            end
        endcase
    end

    // Occupancy register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= OCC_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Head entry: loads a fresh decode or advances the tail entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_imm_r    <= {XLEN{1'b0}};
            head_target_r <= {XLEN{1'b0}};
            head_tag_r    <= {TAG_W{1'b0}};
            head_err_r    <= 1'b0;
        end else if (head_from_in_s) begin
            head_imm_r    <= dec_imm_s;
            head_target_r <= dec_target_s;
            head_tag_r    <= in_tag;
            head_err_r    <= dec_err_s;
        end else if (head_from_tail_s) begin
            head_imm_r    <= tail_imm_r;
            head_target_r <= tail_target_r;
            head_tag_r    <= tail_tag_r;
            head_err_r    <= tail_err_r;
        end
    end

    // Tail entry: captures a decode while the head is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tail_imm_r    <= {XLEN{1'b0}};
            tail_target_r <= {XLEN{1'b0}};
            tail_tag_r    <= {TAG_W{1'b0}};
            tail_err_r    <= 1'b0;
        end else if (tail_from_in_s) begin
            tail_imm_r    <= dec_imm_s;
            tail_target_r <= dec_target_s;
            tail_tag_r    <= in_tag;
            tail_err_r    <= dec_err_s;
        end
    end

endmodule

// File: tb/tb_ysyx_25020081_imm_pipe.sv
// Directed self-checking bench for ysyx_25020081_imm_pipe: an XLEN=32
// instance for formats, queueing and reset, plus an XLEN=64 instance for
// the wide sign/zero-extension cases.
module tb_ysyx_25020081_imm_pipe;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [24:0] in_inst;
    logic [2:0]  in_ext_op;
    logic [31:0] in_pc;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [31:0] out_target;
    logic [3:0]  out_tag;
    logic        out_err;

    logic        w_in_valid;
    logic        w_in_ready;
    logic [24:0] w_in_inst;
    logic [2:0]  w_in_ext_op;
    logic [63:0] w_in_pc;
    logic [3:0]  w_in_tag;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [63:0] w_out_imm;
    logic [63:0] w_out_target;
    logic [3:0]  w_out_tag;
    logic        w_out_err;

    int errors;
    int checks;

    logic [24:0] v_inst   [9];
    logic [2:0]  v_op     [9];
    logic [31:0] v_pc     [9];
    logic [31:0] v_imm    [9];
    logic [31:0] v_target [9];
    logic        v_err    [9];

    ysyx_25020081_imm_pipe #(.XLEN(32), .TAG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .in_ext_op (in_ext_op),
        .in_pc     (in_pc),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_target(out_target),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    ysyx_25020081_imm_pipe #(.XLEN(64), .TAG_W(4)) dut64 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .in_inst   (w_in_inst),
        .in_ext_op (w_in_ext_op),
        .in_pc     (w_in_pc),
        .in_tag    (w_in_tag),
        .out_valid (w_out_valid),
        .out_ready (w_out_ready),
        .out_imm   (w_out_imm),
        .out_target(w_out_target),
        .out_tag   (w_out_tag),
        .out_err   (w_out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: valid=%b ready=%b want 0/0", out_valid, in_ready);
        end
        checks++;
        if (out_imm !== 32'h0 || out_target !== 32'h0 || out_tag !== 4'h0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: imm=%h tgt=%h tag=%h err=%b want zeros",
                     out_imm, out_target, out_tag, out_err);
        end
        checks++;
        if (w_out_valid !== 1'b0 || w_out_imm !== 64'h0) begin
            errors++;
            $display("FAIL reset_64: valid=%b imm=%h want 0/0", w_out_valid, w_out_imm);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_formats();
        v_inst   = '{25'h1FFE001, 25'h0010000, 25'h1FC225C, 25'h1FC0019, 25'h1000001,
                     25'h007E000, 25'h0001F00, 25'h1FFFFFF, 25'h1FFE001};
        v_op     = '{3'd0, 3'd4, 3'd2, 3'd3, 3'd1, 3'd5, 3'd6, 3'd7, 3'd0};
        v_pc     = '{32'h00001000, 32'h80000000, 32'h00000100, 32'h00002000, 32'h00000010,
                     32'h00000000, 32'h00000040, 32'h12345678, 32'h00000000};
`ifdef YSYX_25020081_IMM_ZICSR_EN
        v_imm    = '{32'hFFFFFFFF, 32'h8, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h80000000,
                     32'h1F, 32'h1F, 32'h0, 32'hFFFFFFFF};
        v_target = '{32'h00000FFF, 32'h80000008, 32'h000000FC, 32'h00001FF8, 32'h80000010,
                     32'h1F, 32'h5F, 32'h12345678, 32'hFFFFFFFF};
        v_err    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
        v_imm    = '{32'hFFFFFFFF, 32'h8, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h80000000,
                     32'h1F, 32'h0, 32'h0, 32'hFFFFFFFF};
        v_target = '{32'h00000FFF, 32'h80000008, 32'h000000FC, 32'h00001FF8, 32'h80000010,
                     32'h1F, 32'h40, 32'h12345678, 32'hFFFFFFFF};
        v_err    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid  = 1'b1;
            in_inst   = v_inst[i];
            in_ext_op = v_op[i];
            in_pc     = v_pc[i];
            in_tag    = 4'(i + 1);
            step();
            checks++;
            if (out_valid !== 1'b1 || out_tag !== 4'(i + 1) || out_imm !== v_imm[i] ||
                out_target !== v_target[i] || out_err !== v_err[i]) begin
                errors++;
                $display("FAIL fmt%0d: v=%b tag=%h imm=%h tgt=%h err=%b want 1 %h %h %h %b",
                         i, out_valid, out_tag, out_imm, out_target, out_err,
                         4'(i + 1), v_imm[i], v_target[i], v_err[i]);
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL fmt_drain: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_ext_op = 3'd0;
        in_pc     = 32'h0;
        in_valid  = 1'b1;
        in_tag    = 4'd1;
        in_inst   = 25'(1 << 13);
        step();
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 4'd1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: v=%b tag=%h rdy=%b want 1 1 1", out_valid, out_tag, in_ready);
        end
        in_tag  = 4'd2;
        in_inst = 25'(2 << 13);
        step();
        checks++;
        if (in_ready !== 1'b0 || out_tag !== 4'd1) begin
            errors++;
            $display("FAIL b2b_full: rdy=%b tag=%h want 0 1", in_ready, out_tag);
        end
        in_tag  = 4'd3;
        in_inst = 25'(3 << 13);
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 4'd1 ||
                out_imm !== 32'h1 || out_target !== 32'h1 || out_err !== 1'b0) begin
                errors++;
                $display("FAIL b2b_stall%0d: rdy=%b v=%b tag=%h imm=%h tgt=%h want 0 1 1 1 1",
                         k, in_ready, out_valid, out_tag, out_imm, out_target);
            end
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_tag !== 4'd2 || out_imm !== 32'h2 || in_ready !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_pop1: tag=%h imm=%h rdy=%b v=%b want 2 2 1 1",
                     out_tag, out_imm, in_ready, out_valid);
        end
        step();
        checks++;
        if (out_tag !== 4'd3 || out_imm !== 32'h3 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_pop2: tag=%h imm=%h v=%b want 3 3 1", out_tag, out_imm, out_valid);
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_empty: v=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_ext_op = 3'd0;
        in_pc     = 32'h0;
        in_inst   = 25'h0;
        in_valid  = 1'b1;
        in_tag    = 4'hA;
        step();
        in_tag    = 4'hB;
        step();
        in_valid  = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_tag !== 4'hA) begin
            errors++;
            $display("FAIL rst_mid_fill: rdy=%b tag=%h want 0 a", in_ready, out_tag);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_tag !== 4'h0) begin
            errors++;
            $display("FAIL rst_mid_during: v=%b rdy=%b tag=%h want 0 0 0", out_valid, in_ready, out_tag);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_after: v=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        in_valid = 1'b1;
        in_tag   = 4'hC;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 4'hC) begin
            errors++;
            $display("FAIL rst_mid_next: v=%b tag=%h want 1 c", out_valid, out_tag);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_stale: v=%b tag=%h want valid 0", out_valid, out_tag);
        end
    endtask

    task automatic test_xlen64();
        logic [24:0] x_inst [3];
        logic [2:0]  x_op   [3];
        logic [63:0] x_pc   [3];
        logic [63:0] x_imm  [3];
        logic [63:0] x_tgt  [3];
        x_inst = '{25'h1000001, 25'h007E000, 25'h1FFE001};
        x_op   = '{3'd1, 3'd5, 3'd0};
        x_pc   = '{64'h0000000080000000, 64'h0, 64'h10};
        x_imm  = '{64'hFFFFFFFF80000000, 64'h3F, 64'hFFFFFFFFFFFFFFFF};
        x_tgt  = '{64'h0, 64'h3F, 64'hF};
        w_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w_in_valid  = 1'b1;
            w_in_inst   = x_inst[i];
            w_in_ext_op = x_op[i];
            w_in_pc     = x_pc[i];
            w_in_tag    = 4'(i + 4);
            step();
            checks++;
            if (w_out_valid !== 1'b1 || w_out_imm !== x_imm[i] || w_out_target !== x_tgt[i] ||
                w_out_err !== 1'b0 || w_out_tag !== 4'(i + 4)) begin
                errors++;
                $display("FAIL x64_%0d: v=%b imm=%h tgt=%h err=%b tag=%h want 1 %h %h 0 %h",
                         i, w_out_valid, w_out_imm, w_out_target, w_out_err, w_out_tag,
                         x_imm[i], x_tgt[i], 4'(i + 4));
            end
        end
        w_in_valid = 1'b0;
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        in_valid    = 1'b0;
        in_inst     = 25'h0;
        in_ext_op   = 3'd0;
        in_pc       = 32'h0;
        in_tag      = 4'h0;
        out_ready   = 1'b1;
        w_in_valid  = 1'b0;
        w_in_inst   = 25'h0;
        w_in_ext_op = 3'd0;
        w_in_pc     = 64'h0;
        w_in_tag    = 4'h0;
        w_out_ready = 1'b1;
        test_reset();
        test_formats();
        test_back_to_back();
        test_reset_mid();
        test_xlen64();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_25020081_imm_pipe.md
YSYX_25020081_IMM_PIPE -- requirements
Module: ysyx_25020081_imm_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter TAG_W, default 4, width of the opaque tag carried with each request.
REQ-003 SHALL have port clk, input, 1, single clock; all flops on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, request present.
REQ-006 SHALL have port in_ready, output, 1, request accepted when high with in_valid.
REQ-007 SHALL have port in_inst, input, 25, instruction bits [31:7].
REQ-008 SHALL have port in_ext_op, input, 3, immediate format select.
REQ-009 SHALL have port in_pc, input, XLEN, instruction address.
REQ-010 SHALL have port in_tag, input, TAG_W, opaque tag.
REQ-011 SHALL have port out_valid, output, 1, result present.
REQ-012 SHALL have port out_ready, input, 1, result consumed when high with out_valid.
REQ-013 SHALL have port out_imm, output, XLEN, extended immediate.
REQ-014 SHALL have port out_target, output, XLEN, in_pc + immediate, modulo 2^XLEN.
REQ-015 SHALL have port out_tag, output, TAG_W, tag of the result.
REQ-016 SHALL have port out_err, output, 1, unsupported ext_op.

Function
REQ-017 ext_op encodings SHALL be: 000 I, 001 U, 010 S, 011 B, 100 J, 101 SHAMT, 110 Z, 111 reserved.
REQ-018 I/S/B/J SHALL be the RISC-V layouts, sign-extended from inst[31] to XLEN; B and J have bit0 = 0.
REQ-019 U SHALL be {inst[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64.
REQ-020 SHAMT SHALL be zero-extended inst[24:20] (XLEN=32) or inst[25:20] (XLEN=64).
REQ-021 Z SHALL be zero-extended inst[19:15] (CSR zimm), subject to REQ-034.
REQ-022 Reserved or disabled encodings SHALL give out_imm = 0, out_target = in_pc, out_err = 1; all others give out_err = 0.
REQ-023 Buffering SHALL be a 2-entry in-order queue, occupancy states EMPTY, ONE, TWO.
REQ-024 Transitions: accept-only SHALL increment, pop-only SHALL decrement, simultaneous accept+pop SHALL hold occupancy.
REQ-025 in_ready SHALL equal (state != TWO); it SHALL NOT depend combinationally on out_ready.
REQ-026 out_valid SHALL equal (state != EMPTY); outputs SHALL be driven from the head entry register only.
REQ-027 Latency SHALL be 1 cycle: request accepted at edge N is visible on outputs after edge N when the queue was empty.
REQ-028 Throughput SHALL be 1 result/cycle while out_ready stays high.
REQ-029 While out_valid && !out_ready, out_imm/out_target/out_tag/out_err SHALL hold stable.
REQ-030 Results SHALL leave in acceptance order; no drop, no duplication.

Reset
REQ-031 rst_n low SHALL immediately force state EMPTY: out_valid = 0, in_ready = 1 (while low, in_ready 0 is also acceptable only if documented; chosen: 1 after release only — in_ready = 0 during reset).
REQ-032 out_imm, out_target, out_tag, out_err SHALL reset to 0; in-flight entries are discarded.
REQ-033 Reset assertion mid-transfer SHALL lose queued entries with no partial output.

Configuration
REQ-034 Macro YSYX_25020081_IMM_ZICSR_EN: defined -> ext_op 110 decodes Z per REQ-021; undefined -> 110 treated as reserved per REQ-022.

Structure
REQ-035 Package ysyx_25020081_imm_pkg SHALL hold the ext_op constants and the occupancy state typedef.
REQ-036 Sub-module ysyx_25020081_imm_dec SHALL be the combinational format decoder (inst, ext_op -> imm, err); the adder and queue sit in the top.

Verification
REQ-037 XLEN=32, inst 0xFFF00093>>7, op I -> one cycle later out_imm 0xFFFFFFFF, out_err 0.
REQ-038 op J, inst 0x0080006F>>7, pc 0x80000000 -> out_imm 0x00000008, out_target 0x80000008.
REQ-039 XLEN=64, op U, inst 0x800000B7>>7 -> out_imm 0xFFFFFFFF80000000.
REQ-040 out_ready low, three back-to-back requests tags 1,2,3 -> in_ready low after two accepts; release gives tags 1,2,3 in order, outputs stable while stalled.
REQ-041 op 111, and op 110 with macro undefined -> out_imm 0, out_target = pc, out_err 1.
REQ-042 rst_n pulsed low with state TWO -> out_valid 0 during reset, no stale tag emitted after release.
